// File: rtl/ram_accum_ctrl.sv
// Read-modify-write accumulator controller for an external single-port, read-first RAM
// with 1-cycle registered read data: clear sweep, accumulate, readout and sticky saturation.
module ram_accum_ctrl #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_inc,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              sat,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_di,
  input  logic [DATA_W-1:0] ram_do
);

  typedef enum logic [2:0] {
    S_CLR    = 3'd0,
    S_IDLE   = 3'd1,
    S_ACC_RD = 3'd2,
    S_ACC_WR = 3'd3,
    S_RD_RD  = 3'd4,
    S_RD_OUT = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // MSB of the result flags a carry-out; the low word is clamped to all-ones in that case.
  function automatic logic [DATA_W:0] sat_add(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[DATA_W]) begin
      sat_add = {1'b1, {DATA_W{1'b1}}};
    end else begin
      sat_add = sum;
    end
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_inc;
  logic                r_sat;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;
  // Low only in the first cycle after reset release, so RAM strobes stay quiet during reset.
  logic                r_live;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_inc_nxt;
  logic                w_sat_nxt;
  logic [DATA_W-1:0]   w_rd_data_nxt;
  logic                w_rd_valid_nxt;
  logic                w_in_ready;
  logic                w_ram_en;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_di;
  logic [DATA_W:0]     w_acc;

  assign w_acc = sat_add(ram_do, r_inc);

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_CLR;
      r_cnt      <= {ADDR_W{1'b0}};
      r_addr     <= {ADDR_W{1'b0}};
      r_inc      <= {DATA_W{1'b0}};
      r_sat      <= 1'b0;
      r_rd_data  <= {DATA_W{1'b0}};
      r_rd_valid <= 1'b0;
      r_live     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_inc      <= w_inc_nxt;
      r_sat      <= w_sat_nxt;
      r_rd_data  <= w_rd_data_nxt;
      r_rd_valid <= w_rd_valid_nxt;
      r_live     <= 1'b1;
    end
  end

  // Next-state and RAM strobe decode; strobes depend on registers only.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_addr_nxt     = r_addr;
    w_inc_nxt      = r_inc;
    w_sat_nxt      = r_sat;
    w_rd_data_nxt  = r_rd_data;
    w_rd_valid_nxt = 1'b0;
    w_in_ready     = 1'b0;
    w_ram_en       = 1'b0;
    w_ram_we       = 1'b0;
    w_ram_addr     = r_addr;
    w_ram_di       = {DATA_W{1'b0}};
    case (r_state)
      S_CLR: begin
        w_ram_addr = r_cnt;
        if (r_live) begin
          w_ram_en = 1'b1;
          w_ram_we = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt   = {ADDR_W{1'b0}};
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      S_IDLE: begin
        w_in_ready = !clr && !rd_req;
        if (clr) begin
          w_state_nxt = S_CLR;
          w_cnt_nxt   = {ADDR_W{1'b0}};
          w_sat_nxt   = 1'b0;
        end else if (rd_req) begin
          w_state_nxt = S_RD_RD;
          w_addr_nxt  = rd_addr;
        end else if (in_valid) begin
          w_state_nxt = S_ACC_RD;
          w_addr_nxt  = in_addr;
          w_inc_nxt   = in_inc;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACC_RD: begin
        w_ram_en    = 1'b1;
        w_state_nxt = S_ACC_WR;
      end
      S_ACC_WR: begin
        // The write lands before the next read can issue, so same-address streams need no bypass.
        w_ram_en    = 1'b1;
        w_ram_we    = 1'b1;
        w_ram_di    = w_acc[DATA_W-1:0];
        w_state_nxt = S_IDLE;
        if (w_acc[DATA_W]) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_sat_nxt = r_sat;
        end
      end
      S_RD_RD: begin
        w_ram_en    = 1'b1;
        w_state_nxt = S_RD_OUT;
      end
      S_RD_OUT: begin
        w_rd_data_nxt  = ram_do;
        w_rd_valid_nxt = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_CLR;
        w_cnt_nxt   = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign in_ready = w_in_ready;
  assign busy     = (r_state != S_IDLE);
  assign sat      = r_sat;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign ram_en   = w_ram_en;
  assign ram_we   = w_ram_we;
  assign ram_addr = w_ram_addr;
  assign ram_di   = w_ram_di;

endmodule

// File: tb/tb_ram_accum_ctrl.sv
// Bench for ram_accum_ctrl: behavioural RAM, cycle-level transaction model and directed plus
// randomized stimulus.
module tb_ram_accum_ctrl;
  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n, clr, in_valid, in_ready, rd_req, rd_valid, busy, sat;
  logic          ram_en, ram_we;
  logic [AW-1:0] in_addr, rd_addr, ram_addr;
  logic [DW-1:0] in_inc, rd_data, ram_di, ram_do;
  logic [DW-1:0] ram [DEPTH];

  int cyc   = 0;
  int n_vec = 0;
  int n_err = 0;

  // model state
  int m_mem [DEPTH];
  int m_free_at    = 0;
  int m_clr_start  = -1000;
  bit m_sat        = 1'b0;
  int m_sat_set_at = -1;
  int m_op         = 0;
  int m_op_cyc     = -1000;
  int m_op_addr    = 0;
  int m_op_data    = 0;
  int rdq_cyc [$];
  int rdq_dat [$];

  ram_accum_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_inc(in_inc),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .sat(sat),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port read-first RAM, preloaded with garbage.
  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
    ram_do = '0;
    forever begin
      @(posedge clk);
      if (ram_en) begin
        if (ram_we) ram[ram_addr] <= ram_di;
        ram_do <= ram[ram_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin : cmp_blk
    bit idle, rv;
    int s;
    if (!rst_n) begin
      chk("rst_sat", sat, 0);        chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0); chk("rst_in_ready", in_ready, 0);
      chk("rst_busy", busy, 1);      chk("rst_ram_en", ram_en, 0);
      chk("rst_ram_we", ram_we, 0);  chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_di", ram_di, 0);
      m_free_at = cyc + 66; m_clr_start = cyc + 2;
      m_sat = 0; m_sat_set_at = -1; m_op = 0;
      rdq_cyc.delete(); rdq_dat.delete();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    end else begin
      if (m_sat_set_at >= 0 && cyc >= m_sat_set_at) begin m_sat = 1; m_sat_set_at = -1; end
      idle = (cyc >= m_free_at);
      chk("busy", busy, !idle);
      chk("in_ready", in_ready, idle && !clr && !rd_req);
      chk("sat", sat, m_sat);
      rv = (rdq_cyc.size() > 0 && rdq_cyc[0] == cyc);
      chk("rd_valid", rd_valid, rv);
      if (rv) chk("rd_data", rd_data, rdq_dat[0]);
      if (rdq_cyc.size() > 0 && rdq_cyc[0] <= cyc) begin
        void'(rdq_cyc.pop_front()); void'(rdq_dat.pop_front());
      end
      if (cyc >= m_clr_start && cyc < m_clr_start + DEPTH) begin
        chk("clr_en", ram_en, 1); chk("clr_we", ram_we, 1);
        chk("clr_addr", ram_addr, cyc - m_clr_start); chk("clr_di", ram_di, 0);
      end else if (m_op != 0 && cyc == m_op_cyc + 1) begin
        chk("rdcyc_en", ram_en, 1); chk("rdcyc_we", ram_we, 0);
        chk("rdcyc_addr", ram_addr, m_op_addr);
      end else if (m_op == 1 && cyc == m_op_cyc + 2) begin
        chk("wr_en", ram_en, 1); chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, m_op_addr); chk("wr_di", ram_di, m_op_data);
      end else begin
        chk("quiet_en", ram_en, 0); chk("quiet_we", ram_we, 0);
      end
      if (idle) begin
        if (clr) begin
          m_clr_start = cyc + 1; m_free_at = cyc + 65; m_sat = 0;
          for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
        end else if (rd_req) begin
          rdq_cyc.push_back(cyc + 3); rdq_dat.push_back(m_mem[rd_addr]);
          m_op = 2; m_op_cyc = cyc; m_op_addr = rd_addr; m_free_at = cyc + 3;
        end else if (in_valid) begin
          s = m_mem[in_addr] + int'(in_inc);
          if (s > 65535) begin s = 65535; m_sat_set_at = cyc + 3; end
          m_mem[in_addr] = s;
          m_op = 1; m_op_cyc = cyc; m_op_addr = in_addr; m_op_data = s; m_free_at = cyc + 3;
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic send(input int a, input int inc, output int tcyc);
    bit ok = 0;
    @(posedge clk); #1;
    in_valid = 1; in_addr = AW'(a); in_inc = DW'(inc);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    tcyc = cyc;
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 0; in_addr = AW'($urandom); in_inc = DW'($urandom);
  endtask

  task automatic rd(input int a, output int d);
    bit ok = 0;
    int n0;
    @(posedge clk); #1;
    rd_req = 1; rd_addr = AW'(a);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    n0 = cyc;
    if (!ok) chk("rd_accept_timeout", 0, 1);
    @(posedge clk); #1;
    rd_req = 0; rd_addr = AW'($urandom);
    ok = 0; d = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rd_valid) begin ok = 1; d = int'(rd_data); break; end
    end
    chk("rd_seen", ok, 1);
    if (ok) begin
      chk("rd_latency", cyc - n0, 3);
      @(negedge clk);
      chk("rd_valid_pulse", rd_valid, 0);
    end
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    clr = 1;
    wait_idle();
    @(posedge clk); #1;
    clr = 0;
  endtask

  initial begin : drv
    int d, t, wcount, nz, cnt, last, sel, a, inc;
    rst_n = 0; clr = 0; in_valid = 0; in_addr = '0; in_inc = '0; rd_req = 0; rd_addr = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // post-reset sweep
    wcount = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ram_en && ram_we && ram_di == '0) wcount++;
      if (!busy) break;
    end
    chk("sweep_writes", wcount, 64);
    chk("ready_after_sweep", in_ready, 1);
    nz = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] != '0) nz++;
    chk("ram_zeroed", nz, 0);

    // basic accumulate and readout
    send(5, 10, t); send(5, 7, t); send(9, 1, t);
    rd(5, d); chk("acc_a5", d, 17);
    rd(9, d); chk("acc_a9", d, 1);

    // exact full scale without carry, then saturation and clear
    send(4, 'hFFFE, t); send(4, 1, t);
    rd(4, d); chk("full_no_sat_val", d, 'hFFFF); chk("full_no_sat_flag", sat, 0);
    send(3, 'hFFF0, t); send(3, 'h0020, t);
    rd(3, d); chk("sat_val", d, 'hFFFF); chk("sat_flag", sat, 1);
    do_clr();
    @(negedge clk); chk("sat_cleared", sat, 0);
    wait_idle();
    rd(3, d); chk("clr_a3", d, 0);

    // clr outranks rd_req and in_valid
    @(posedge clk); #1;
    in_valid = 1; rd_req = 1; clr = 1; in_addr = 2; in_inc = 5; rd_addr = 2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); chk("all_hi_ready", in_ready, 0);
    end
    chk("all_hi_busy", busy, 1);
    @(posedge clk); #1;
    in_valid = 0; rd_req = 0; clr = 0;
    wait_idle();
    rd(2, d); chk("all_hi_a2", d, 0);

    // reset during the write cycle of an accumulate
    send(7, 4, t); send(7, 4, t);
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 1); chk("midrst_en", ram_en, 0); chk("midrst_we", ram_we, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    wait_idle();
    rd(7, d); chk("midrst_a7", d, 0);

    // back-to-back stream to one address
    @(posedge clk); #1;
    in_valid = 1; in_addr = 0; in_inc = 1;
    cnt = 0; last = -1;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (last >= 0) chk("xfer_spacing", cyc - last, 3);
        last = cyc; cnt++;
        if (cnt == 32) break;
      end
    end
    @(posedge clk); #1 in_valid = 0;
    chk("stream_count", cnt, 32);
    wait_idle();
    rd(0, d); chk("stream_a0", d, 32);

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 200; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 10) begin
        a   = (sel < 7) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1);
        inc = (sel < 2) ? $urandom_range(32'h8000, 32'hFFFF) : $urandom_range(0, 400);
        send(a, inc, t);
        if ($urandom_range(0, 7) == 0) begin
          clr = 1;
          @(posedge clk); #1 clr = 0;
        end
      end else if (sel < 16) begin
        rd($urandom_range(0, 7), d);
      end else if (sel < 19) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end else begin
        do_clr();
      end
    end

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ram_accum_ctrl.md
RAM_ACCUM_CTRL -- requirements
Module: ram_accum_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 6, meaning the RAM address width (depth 2**ADDR_W).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the RAM word and accumulator width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port clr, input, 1, which requests a clear sweep of all RAM words to 0.
REQ-006 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_addr (input, ADDR_W) and in_inc (input, DATA_W), forming the accumulate-request handshake.
REQ-007 The block SHALL have ports rd_req (input, 1) and rd_addr (input, ADDR_W), forming the readout request.
REQ-008 The block SHALL have ports rd_valid (output, 1) and rd_data (output, DATA_W), forming the readout response.
REQ-009 The block SHALL have port busy, output, 1, high in every state except IDLE.
REQ-010 The block SHALL have port sat, output, 1, a sticky flag set when any accumulation saturated.
REQ-011 The block SHALL drive the RAM through ram_en (output, 1), ram_we (output, 1), ram_addr (output, ADDR_W) and ram_di (output, DATA_W).
REQ-012 The block SHALL receive the RAM read data on ram_do (input, DATA_W); the RAM is single-port, read-first, with 1-cycle registered read data.

Function
REQ-013 The block SHALL implement FSM states CLR, IDLE, ACC_RD, ACC_WR, RD_RD and RD_OUT.
REQ-014 In CLR, each cycle SHALL drive ram_en=1, ram_we=1, ram_di=0 and ram_addr=cnt; cnt SHALL run 0 to 2**ADDR_W-1, then the FSM SHALL go to IDLE (64 cycles at the default).
REQ-015 Priority in IDLE SHALL be clr (to CLR with cnt=0), then rd_req (to RD_RD), then in_valid (to ACC_RD).
REQ-016 in_ready SHALL equal (state==IDLE) && !clr && !rd_req; a transfer occurs only when in_valid && in_ready.
REQ-017 On transfer, in_addr and in_inc SHALL be latched; inputs are then don't-care until the next transfer.
REQ-018 ACC_RD SHALL drive ram_en=1, ram_we=0 and ram_addr=latched address, then go to ACC_WR.
REQ-019 ACC_WR SHALL drive ram_en=1, ram_we=1 and ram_addr=latched address, then return to IDLE.
REQ-020 In ACC_WR, ram_di SHALL be ram_do + latched inc, saturated to 2**DATA_W-1 on carry-out; on saturation sat SHALL be set.
REQ-021 Throughput SHALL be one accumulate per 3 cycles; consecutive same-address samples SHALL need no forwarding because the write completes before the next read.
REQ-022 RD_RD SHALL drive ram_en=1, ram_we=0 and ram_addr=rd_addr latched in IDLE, then go to RD_OUT.
REQ-023 In RD_OUT, rd_data SHALL be registered from ram_do and rd_valid SHALL pulse high for exactly 1 cycle in the following cycle; the FSM SHALL then return to IDLE.
REQ-024 Read latency SHALL be 3 cycles from the rd_req sample edge to rd_valid high.
REQ-025 Outside the states above, ram_en and ram_we SHALL be 0.
REQ-026 clr asserted while the FSM is in ACC_*, RD_* or CLR SHALL be ignored; the in-flight operation completes and clr is re-sampled in IDLE.
REQ-027 sat SHALL clear only on reset or on entry to CLR.
REQ-028 ram_en, ram_we, ram_addr, ram_di, busy, sat and rd_valid SHALL be decoded from registers only; in_ready is the only output with a combinational input path.

Reset
REQ-029 While rst_n=0, the FSM SHALL be in CLR with cnt=0, and outputs SHALL be: sat=0, rd_valid=0, rd_data=0, in_ready=0, busy=1, ram_en=0, ram_we=0, ram_addr=0 and ram_di=0.
REQ-030 After rst_n deasserts, the block SHALL perform a full clear sweep before first asserting in_ready.
REQ-031 Reset asserted mid-operation SHALL abort it immediately; any partially updated RAM word is overwritten by the post-reset sweep.

Verification
REQ-032 Release reset -> exactly 64 write cycles (addr 0..63, di=0), then busy=0 and in_ready=1.
REQ-033 Send samples (5,10), (5,7), (9,1), then rd_req addr 5 -> rd_data=17, rd_valid 1 cycle; rd_req addr 9 -> 1.
REQ-034 Send (3,0xFFF0), then (3,0x0020) -> read of addr 3 returns 0xFFFF and sat=1; assert clr -> sat=0 and addr 3 reads 0.
REQ-035 Hold in_valid, rd_req and clr all high in IDLE -> CLR entered first, no sample transferred, in_ready=0 throughout.
REQ-036 Assert rst_n=0 during ACC_WR of (7,4) -> all outputs at reset values; after the sweep, addr 7 reads 0.
REQ-037 Stream 32 back-to-back samples to addr 0 with inc=1 -> a transfer every 3rd cycle and final read of addr 0 = 32.
